// File: rtl/z8s180_bus_ctl.sv
// Z8S180 board glue: EXTAL divider, reset stretcher, boot-ROM shadow
// decode with an I/O disable port, and SRAM /WAIT generation.
module z8s180_bus_ctl #(
  parameter int          ADDR_WIDTH    = 20,
  parameter int          ROM_ADDR_BITS = 9,
  parameter int          CLK_DIV_BITS  = 1,
  parameter int          RESET_CYCLES  = 16,
  parameter logic [7:0]  ROM_CTL_PORT  = 8'h3F,
  parameter int          WAIT_STATES   = 0
) (
  input  logic                     hwclk,
  input  logic                     reset,
  input  logic                     s1_n,
  input  logic [ADDR_WIDTH-1:0]    a,
  input  logic [7:0]               d_in,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     rfsh_n,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [7:0]               rom_data,
  output logic [7:0]               d_out,
  output logic                     d_oe,
  output logic                     extal,
  output logic                     reset_n,
  output logic                     ce_n,
  output logic                     oe_n,
  output logic                     we_n,
  output logic                     wait_n,
  output logic                     rom_en
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int WCW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_STATES);

  // Synchronisers, bit order {s1_n, mreq_n, iorq_n, wr_n}
  logic [3:0] sync0_q;
  logic [3:0] sync1_q;
  logic       s1_n_s;
  logic       mreq_n_s;
  logic       iorq_n_s;
  logic       wr_n_s;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      sync0_q <= '1;
      sync1_q <= '1;
    end else begin
      sync0_q <= {s1_n, mreq_n, iorq_n, wr_n};
      sync1_q <= sync0_q;
    end
  end

  assign s1_n_s   = sync1_q[3];
  assign mreq_n_s = sync1_q[2];
  assign iorq_n_s = sync1_q[1];
  assign wr_n_s   = sync1_q[0];

  logic [CLK_DIV_BITS-1:0] ctr_q;

  always_ff @(posedge hwclk) begin
    if (reset) ctr_q <= '0;
    else       ctr_q <= ctr_q + 1'b1;
  end

  assign extal = ctr_q[CLK_DIV_BITS-1];

  logic [RCW-1:0] rst_ctr_q;
  logic [RCW-1:0] rst_ctr_d;
  logic           reset_n_q;

  always_comb begin
    rst_ctr_d = rst_ctr_q;
    if (!s1_n_s)
      rst_ctr_d = RST_LOAD;
    else if (rst_ctr_q != '0)
      rst_ctr_d = rst_ctr_q - 1'b1;
  end

  // reset_n trails the terminal count by one flop so release is glitch free
  always_ff @(posedge hwclk) begin
    if (reset) begin
      rst_ctr_q <= RST_LOAD;
      reset_n_q <= 1'b0;
    end else begin
      rst_ctr_q <= rst_ctr_d;
      reset_n_q <= (rst_ctr_q == '0) && s1_n_s;
    end
  end

  assign reset_n = reset_n_q;

  logic       io_wr;
  logic       io_wr_q;
  logic [7:0] port_q;
  logic       d0_q;
  logic       rom_en_q;

  assign io_wr = ~iorq_n_s & ~wr_n_s;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      io_wr_q  <= 1'b0;
      port_q   <= '0;
      d0_q     <= 1'b0;
      rom_en_q <= 1'b1;
    end else begin
      io_wr_q <= io_wr;
      if (io_wr) begin
        port_q <= a[7:0];
        d0_q   <= d_in[0];
      end
      if (!reset_n_q)
        rom_en_q <= 1'b1;
      else if (io_wr_q && !io_wr && port_q == ROM_CTL_PORT)
        rom_en_q <= ~d0_q;
    end
  end

  assign rom_en = rom_en_q;

  logic unused_d;
  assign unused_d = ^d_in[7:1];

  logic in_rom;

  assign in_rom   = rom_en_q &&
                    (a[ADDR_WIDTH-1:ROM_ADDR_BITS] == '0);
  assign d_oe     = in_rom & ~mreq_n & ~rd_n & rfsh_n;
  assign d_out    = rom_data;
  assign rom_addr = a[ROM_ADDR_BITS-1:0];
  assign ce_n     = ~(~mreq_n & rfsh_n & ~in_rom);
  assign oe_n     = mreq_n | rd_n;
  assign we_n     = mreq_n | wr_n;

  logic           mreq_prev_q;
  logic           sram_start;
  logic [WCW-1:0] wctr_q;
  logic [WCW-1:0] wctr_d;
  logic           wait_n_q;

  assign sram_start = mreq_prev_q & ~mreq_n_s & rfsh_n & ~in_rom;

  always_comb begin
    wctr_d = wctr_q;
    if (sram_start)
      wctr_d = WAIT_LOAD;
    else if (wctr_q != '0)
      wctr_d = wctr_q - 1'b1;
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      mreq_prev_q <= 1'b1;
      wctr_q      <= '0;
      wait_n_q    <= 1'b1;
    end else begin
      mreq_prev_q <= mreq_n_s;
      wctr_q      <= wctr_d;
      wait_n_q    <= (wctr_d == '0);
    end
  end

  assign wait_n = wait_n_q;

endmodule
